sr_flipflop: RTL and testbench



---
 rtl/sr_pkg.sv | 24 ++
 rtl/sr_bit.sv | 70 +++++++
 rtl/sr_flipflop.sv | 52 +++++
 tb/tb_sr_flipflop.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared encodings for the SR flip-flop bank.
// Holds the forbidden-input policy codes and the (S,R) command enum.
package sr_pkg;

  localparam int SR_INV_NOR  = 0;
  localparam int SR_INV_SET  = 1;
  localparam int SR_INV_RST  = 2;
  localparam int SR_INV_HOLD = 3;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_RESET   = 2'b01,
    SR_SET     = 2'b10,
    SR_INVALID = 2'b11
  } sr_cmd_t;

  function automatic sr_cmd_t sr_cmd(
    input logic s,
    input logic r
  );
    return sr_cmd_t'({s, r});
  endfunction

endpackage

// File: rtl/sr_bit.sv
// Single SR storage cell: next-state decode plus forbidden-input flag.
// invalid_nxt is exposed so the top can update its sticky flag on the same edge.
module sr_bit
  import sr_pkg::*;
#(
  parameter int INVALID_MODE = SR_INV_NOR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar,
  output logic invalid,
  output logic invalid_nxt
);

  sr_cmd_t cmd;
  logic    q_nxt;
  logic    qb_nxt;

  always_comb begin
    cmd         = sr_cmd(s, r);
    q_nxt       = q;
    qb_nxt      = q_bar;
    invalid_nxt = 1'b0;
    unique case (cmd)
      SR_HOLD: begin
        // Leaving the both-low NOR state settles to reset, no race.
        if (!q && !q_bar) begin
          qb_nxt = 1'b1;
        end
      end
      SR_SET: begin
        q_nxt  = 1'b1;
        qb_nxt = 1'b0;
      end
      SR_RESET: begin
        q_nxt  = 1'b0;
        qb_nxt = 1'b1;
      end
      SR_INVALID: begin
        invalid_nxt = 1'b1;
        if (INVALID_MODE == SR_INV_NOR) begin
          q_nxt  = 1'b0;
          qb_nxt = 1'b0;
        end else if (INVALID_MODE == SR_INV_SET) begin
          q_nxt  = 1'b1;
          qb_nxt = 1'b0;
        end else if (INVALID_MODE == SR_INV_RST) begin
          q_nxt  = 1'b0;
          qb_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= 1'b0;
      q_bar   <= 1'b1;
      invalid <= 1'b0;
    end else begin
      q       <= q_nxt;
      q_bar   <= qb_nxt;
      invalid <= invalid_nxt;
    end
  end

endmodule

// File: rtl/sr_flipflop.sv
// Bank of WIDTH independent clocked SR bits with a shared sticky
// forbidden-input flag, cleared only by synchronous reset.
module sr_flipflop
  import sr_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int INVALID_MODE = SR_INV_NOR
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] INVALID,
  output logic             INVALID_STICKY
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flipflop: WIDTH must be >= 1");
  end

  if (INVALID_MODE < 0 || INVALID_MODE > 3) begin : g_bad_mode
    $error("sr_flipflop: INVALID_MODE must be 0..3");
  end

  logic [WIDTH-1:0] inv_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_bit #(
      .INVALID_MODE(INVALID_MODE)
    ) u_bit (
      .clk        (CLK),
      .rst_n      (RST_N),
      .s          (S[i]),
      .r          (R[i]),
      .q          (Q[i]),
      .q_bar      (Q_bar[i]),
      .invalid    (INVALID[i]),
      .invalid_nxt(inv_nxt[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      INVALID_STICKY <= 1'b0;
    end else if (|inv_nxt) begin
      INVALID_STICKY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_flipflop.sv
// Scoreboarded directed bench: four 1-bit banks (one per invalid
// mode) sharing stimulus, plus a 4-bit mode-0 bank.
module tb_sr_flipflop;
  import sr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s1, r1;
  logic [3:0] s4, r4;

  logic [3:0] q1, qb1, inv1, st1;
  logic [3:0] q4, qb4, inv4;
  logic       st4;

  for (genvar m = 0; m < 4; m++) begin : g_m
    sr_flipflop #(
      .WIDTH(1),
      .INVALID_MODE(m)
    ) u_dut (
      .CLK           (clk),
      .RST_N         (rst_n),
      .S             (s1),
      .R             (r1),
      .Q             (q1[m]),
      .Q_bar         (qb1[m]),
      .INVALID       (inv1[m]),
      .INVALID_STICKY(st1[m])
    );
  end

  sr_flipflop #(
    .WIDTH(4),
    .INVALID_MODE(SR_INV_NOR)
  ) u_wide (
    .CLK           (clk),
    .RST_N         (rst_n),
    .S             (s4),
    .R             (r4),
    .Q             (q4),
    .Q_bar         (qb4),
    .INVALID       (inv4),
    .INVALID_STICKY(st4)
  );

  typedef struct packed {
    logic [3:0] q1, qb1, inv1, st1;
    logic [3:0] q4, qb4, inv4;
    logic       st4;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] mq1, mqb1, mst1;
  logic [3:0] mq4, mqb4;
  logic       mst4;

  // returns {q, q_bar, invalid}
  function automatic logic [2:0] mbit(
    input int   mode,
    input logic s,
    input logic r,
    input logic q,
    input logic qb
  );
    if (!s && !r) begin
      if (!q && !qb) return 3'b010;
      return {q, qb, 1'b0};
    end
    if (s && !r) return 3'b100;
    if (!s && r) return 3'b010;
    case (mode)
      SR_INV_NOR: return 3'b001;
      SR_INV_SET: return 3'b101;
      SR_INV_RST: return 3'b011;
      default:    return {q, qb, 1'b1};
    endcase
  endfunction

  task automatic step(
    input string      tag,
    input logic       rst,
    input logic       s1v,
    input logic       r1v,
    input logic [3:0] s4v,
    input logic [3:0] r4v,
    input bit         glitch
  );
    exp_t       e;
    logic [2:0] b;
    exp_t       g;
    @(negedge clk);
    rst_n = rst;
    s1 = s1v; r1 = r1v;
    s4 = s4v; r4 = r4v;
    e = '0;
    for (int m = 0; m < 4; m++) begin
      if (!rst) begin
        b = 3'b010;
        mst1[m] = 1'b0;
      end else begin
        b = mbit(m, s1v, r1v, mq1[m], mqb1[m]);
        if (b[0]) mst1[m] = 1'b1;
      end
      mq1[m] = b[2];
      mqb1[m] = b[1];
      e.inv1[m] = b[0];
    end
    if (!rst) mst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!rst) b = 3'b010;
      else b = mbit(SR_INV_NOR, s4v[i], r4v[i], mq4[i], mqb4[i]);
      if (b[0]) mst4 = 1'b1;
      mq4[i] = b[2];
      mqb4[i] = b[1];
      e.inv4[i] = b[0];
    end
    e.q1 = mq1; e.qb1 = mqb1; e.st1 = mst1;
    e.q4 = mq4; e.qb4 = mqb4; e.st4 = mst4;
    sb.push_back(e);
    if (glitch) begin
      #2;
      s1 = ~s1v; r1 = ~r1v;
      s4 = ~s4v; r4 = ~r4v;
      #1;
      s1 = s1v; r1 = r1v;
      s4 = s4v; r4 = r4v;
    end
    @(posedge clk);
    #1;
    g = sb.pop_front();
    for (int m = 0; m < 4; m++) begin
      n_vec++;
      assert ({q1[m], qb1[m], inv1[m], st1[m]} ===
              {g.q1[m], g.qb1[m], g.inv1[m], g.st1[m]})
      else begin
        n_err++;
        $error("FAIL %s mode%0d {q,qb,inv,st} got=%b exp=%b", tag, m,
               {q1[m], qb1[m], inv1[m], st1[m]},
               {g.q1[m], g.qb1[m], g.inv1[m], g.st1[m]});
      end
    end
    n_vec++;
    assert ({q4, qb4, inv4, st4} === {g.q4, g.qb4, g.inv4, g.st4})
    else begin
      n_err++;
      $error("FAIL %s wide {q,qb,inv,st} got=%b exp=%b", tag,
             {q4, qb4, inv4, st4}, {g.q4, g.qb4, g.inv4, g.st4});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 1'b1; r1 = 1'b1;
    s4 = 4'hF; r4 = 4'hF;
    mq1 = 'x; mqb1 = 'x; mst1 = 'x;
    mq4 = 'x; mqb4 = 'x; mst4 = 1'bx;

    step("reset0",    0, 1, 1, 4'hF, 4'hF, 0);
    step("reset1",    0, 1, 1, 4'hF, 4'hF, 0);
    step("set",       1, 1, 0, 4'b0101, 4'b1010, 0);
    step("clear",     1, 0, 1, 4'b1010, 4'b0100, 0);
    step("invalid",   1, 1, 1, 4'b1100, 4'b0110, 0);
    step("exit00",    1, 0, 0, 4'b0000, 4'b0000, 0);
    step("inv2",      1, 1, 1, 4'b1111, 4'b1111, 0);
    step("exit10",    1, 1, 0, 4'b0011, 4'b1100, 0);
    for (int k = 0; k < 5; k++) begin
      step("hold",    1, 0, 0, 4'b0000, 4'b0000, 1);
    end
    step("rst_mid",   0, 1, 0, 4'b1111, 4'b0000, 0);
    step("post_rst",  1, 1, 0, 4'b1001, 4'b0110, 0);
    step("inv_q1",    1, 1, 1, 4'b0001, 4'b0001, 0);
    step("exit01",    1, 0, 1, 4'b0000, 4'b1111, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
